// File: rtl/scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scale_ctrl
// Purpose  : Job controller for a bank of image-scaling engines. An accepted
//            job first zero-fills the frame RAM, then pulses every engine
//            through one idle cycle so the chosen engine starts from reset,
//            then runs that engine and forwards its memory buses until it
//            reports done or a cycle budget runs out.
// Ports    : clk, reset            - clock, async active-high reset
//            start, mode           - job request and job select (11 invalid)
//            eng_go                - one-hot engine run enable
//            eng_done              - per-engine completion levels
//            eng_rom_addr, eng_ram_wraddr, eng_ram_data, eng_ram_wren
//                                  - packed engine buses, engine 0 in LSBs
//            rom_addr, ram_wraddr, ram_data, ram_wren
//                                  - shared ROM / frame RAM buses
//            busy, done, error     - job status
//            active_mode           - mode latched at job acceptance
// Revision : 1.0 - initial release
// ============================================================================
module scale_ctrl #(
    parameter int ADDR_W    = 19,
    parameter int CLR_WORDS = 76800,
    parameter int TIMEOUT   = 1000000,
    parameter int NUM_ENG   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    output logic [NUM_ENG-1:0]        eng_go,
    input  logic [NUM_ENG-1:0]        eng_done,
    input  logic [NUM_ENG*ADDR_W-1:0] eng_rom_addr,
    input  logic [NUM_ENG*ADDR_W-1:0] eng_ram_wraddr,
    input  logic [NUM_ENG*8-1:0]      eng_ram_data,
    input  logic [NUM_ENG-1:0]        eng_ram_wren,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [ADDR_W-1:0]         ram_wraddr,
    output logic [7:0]                ram_data,
    output logic                      ram_wren,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                active_mode
);

    // Counter widths cover the terminal count without wrapping.
    localparam int c_clr_w = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;
    localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_clr_w-1:0] c_clr_last = c_clr_w'(CLR_WORDS - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_clr_w-1:0]   clr_cnt_q, clr_cnt_d;
    logic [c_tmo_w-1:0]   run_cnt_q, run_cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 mode_ok;
    logic                 sel_done;

    // A mode is usable only if it names an engine that exists.
    assign mode_ok = (mode != 2'b11) && (int'(mode) < NUM_ENG);

    // Only the selected engine's completion is observed.
    always_comb begin
        sel_done = 1'b0;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (int'(mode_q) == e) begin
                sel_done = eng_done[e];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            run_cnt_q <= '0;
            mode_q    <= 2'b00;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            run_cnt_q <= run_cnt_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        run_cnt_d = run_cnt_q;
        mode_d    = mode_q;
        done_d    = done_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d = 1'b0;
                    if (mode_ok) begin
                        mode_d    = mode;
                        error_d   = 1'b0;
                        clr_cnt_d = '0;
                        state_d   = S_CLEAR;
                    end else begin
                        // Rejected request: flag it but never start a job.
                        error_d = 1'b1;
                        state_d = (state_q == S_IDLE) ? S_IDLE : S_ERROR;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == c_clr_last) begin
                    clr_cnt_d = '0;
                    state_d   = S_ARM;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_ARM: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // Completion wins over a coincident timeout.
                if (sel_done) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (run_cnt_q == c_tmo_last) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus steering: zero-fill writes in CLEAR, selected engine in RUN,
    // everything quiet otherwise.
    always_comb begin
        eng_go     = '0;
        rom_addr   = '0;
        ram_wraddr = '0;
        ram_data   = 8'h00;
        ram_wren   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                ram_wraddr = ADDR_W'(clr_cnt_q);
                ram_wren   = 1'b1;
            end
            S_RUN: begin
                for (int e = 0; e < NUM_ENG; e++) begin
                    if (int'(mode_q) == e) begin
                        eng_go[e]  = 1'b1;
                        rom_addr   = eng_rom_addr[e*ADDR_W +: ADDR_W];
                        ram_wraddr = eng_ram_wraddr[e*ADDR_W +: ADDR_W];
                        ram_data   = eng_ram_data[e*8 +: 8];
                        ram_wren   = eng_ram_wren[e];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state_q == S_CLEAR) || (state_q == S_ARM) || (state_q == S_RUN);
    assign done        = done_q;
    assign error       = error_q;
    assign active_mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scale_ctrl
// Purpose  : Self-checking bench for scale_ctrl with a reduced clear size and
//            timeout. A job-timeline model predicts every output each cycle;
//            directed jobs add hand-computed latency and count expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scale_ctrl;

    localparam int ADDR_W = 19;
    localparam int CLR    = 64;
    localparam int TMO    = 150;
    localparam int NE     = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic [NE-1:0]        eng_go;
    logic [NE-1:0]        eng_done;
    logic [NE*ADDR_W-1:0] eng_rom_addr;
    logic [NE*ADDR_W-1:0] eng_ram_wraddr;
    logic [NE*8-1:0]      eng_ram_data;
    logic [NE-1:0]        eng_ram_wren;
    logic [ADDR_W-1:0]    rom_addr;
    logic [ADDR_W-1:0]    ram_wraddr;
    logic [7:0]           ram_data;
    logic                 ram_wren;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [1:0]           active_mode;

    scale_ctrl #(
        .ADDR_W    (ADDR_W),
        .CLR_WORDS (CLR),
        .TIMEOUT   (TMO),
        .NUM_ENG   (NE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .eng_go         (eng_go),
        .eng_done       (eng_done),
        .eng_rom_addr   (eng_rom_addr),
        .eng_ram_wraddr (eng_ram_wraddr),
        .eng_ram_data   (eng_ram_data),
        .eng_ram_wren   (eng_ram_wren),
        .rom_addr       (rom_addr),
        .ram_wraddr     (ram_wraddr),
        .ram_data       (ram_data),
        .ram_wren       (ram_wren),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .active_mode    (active_mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- engine stand-ins ----------------
    logic [ADDR_W-1:0] b_rom [NE];
    logic [ADDR_W-1:0] b_wa  [NE];
    logic [7:0]        b_dat [NE];
    logic              b_wren[NE];
    logic              ovr = 1'b0;   // engine 0 drives a fixed write
    int                gocnt[NE];
    int                done_at = 0;  // 0: engine never finishes

    initial begin
        forever begin
            for (int e = 0; e < NE; e++) begin
                b_rom[e]  = ADDR_W'($urandom);
                b_wa[e]   = ADDR_W'($urandom);
                b_dat[e]  = 8'($urandom);
                b_wren[e] = 1'($urandom);
            end
            if (ovr) begin
                b_rom[0]  = 19'h12345;
                b_wa[0]   = 19'd5;
                b_dat[0]  = 8'hA5;
                b_wren[0] = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    end

    always_comb begin
        eng_rom_addr   = '0;
        eng_ram_wraddr = '0;
        eng_ram_data   = '0;
        eng_ram_wren   = '0;
        eng_done       = '0;
        for (int e = 0; e < NE; e++) begin
            eng_rom_addr[e*ADDR_W +: ADDR_W]   = b_rom[e];
            eng_ram_wraddr[e*ADDR_W +: ADDR_W] = b_wa[e];
            eng_ram_data[e*8 +: 8]             = b_dat[e];
            eng_ram_wren[e]                    = b_wren[e];
            // Idle engines shout done constantly; it must be ignored.
            eng_done[e] = eng_go[e] ? (done_at != 0 && gocnt[e] + 1 >= done_at) : 1'b1;
        end
    end

    always @(posedge clk) begin
        for (int e = 0; e < NE; e++) begin
            gocnt[e] <= eng_go[e] ? gocnt[e] + 1 : 0;
        end
    end

    // ---------------- job-timeline model ----------------
    // m_k is the cycle index within an accepted job: 0..CLR-1 clear,
    // CLR arm, CLR+1 onward run (run index m_k-CLR-1).
    logic       m_busy, m_done, m_err;
    logic [1:0] m_mode;
    int         m_k;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_mode <= 2'b00;
            m_k    <= 0;
        end else if (m_busy) begin
            if (m_k > CLR && eng_done[m_mode]) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else if (m_k - CLR - 1 == TMO - 1) begin
                m_busy <= 1'b0;
                m_err  <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (start) begin
            m_done <= 1'b0;
            if (mode != 2'b11) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_mode <= mode;
                m_err  <= 1'b0;
            end else begin
                m_err <= 1'b1;
            end
        end
    end

    int n_wr = 0;
    int n_clr = 0;
    int n_ovr = 0;
    int n_go[NE];

    always @(negedge clk) begin
        logic [NE-1:0]     e_go;
        logic [ADDR_W-1:0] e_rom, e_wa;
        logic [7:0]        e_dat;
        logic              e_wren;
        e_go = '0; e_rom = '0; e_wa = '0; e_dat = 8'h00; e_wren = 1'b0;
        if (m_busy && m_k < CLR) begin
            e_wa   = ADDR_W'(m_k);
            e_wren = 1'b1;
        end else if (m_busy && m_k > CLR) begin
            e_go   = NE'(1 << m_mode);
            e_rom  = b_rom[m_mode];
            e_wa   = b_wa[m_mode];
            e_dat  = b_dat[m_mode];
            e_wren = b_wren[m_mode];
        end
        check("eng_go", 32'(eng_go), 32'(e_go));
        check("rom_addr", 32'(rom_addr), 32'(e_rom));
        check("ram_wraddr", 32'(ram_wraddr), 32'(e_wa));
        check("ram_data", 32'(ram_data), 32'(e_dat));
        check("ram_wren", 32'(ram_wren), 32'(e_wren));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        check("active_mode", 32'(active_mode), 32'(m_mode));
        check("done_and_error", 32'(done & error), 32'd0);
        if (ram_wren) n_wr++;
        if (ram_wren && busy && eng_go == '0) n_clr++;
        if (ovr && eng_go == 3'b001 && ram_wraddr == 19'd5 && ram_data == 8'hA5 && ram_wren)
            n_ovr++;
        for (int e = 0; e < NE; e++) begin
            if (eng_go == NE'(1 << e)) n_go[e]++;
        end
    end

    // ---------------- directed jobs ----------------
    // Returns the number of cycles from acceptance to done/error (-1 if none).
    // p1/p2: cycles at which a spurious start is pulsed; rst_at: reset pulse.
    task automatic run_job(input logic [1:0] m, input int d_at, input int p1,
                           input int p2, input int rst_at, output int lat);
        lat = -1;
        done_at = d_at;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            start = (i == p1) || (i == p2);
            mode  = (i == p1) ? 2'b10 : (i == p2) ? 2'b01 : m;
            if (rst_at != 0 && i == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_go", 32'(eng_go), 32'd0);
                check("rst_wren", 32'(ram_wren), 32'd0);
                check("rst_wraddr", 32'(ram_wraddr), 32'd0);
                check("rst_rom", 32'(rom_addr), 32'd0);
                check("rst_mode", 32'(active_mode), 32'd0);
            end else begin
                reset = 1'b0;
            end
            if (rst_at != 0 && i == rst_at + 3) break;
            @(negedge clk);
            if (done || error) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        mode  = m;
        if (rst_at == 0 && lat < 0) check("job_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, s_clr, s_go, s_wr, s_ovr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_go", 32'(eng_go), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zoom x2, engine done after 100 run cycles: 64 clear + 1 arm + 100 + 1.
        s_clr = n_clr; s_go = n_go[1];
        run_job(2'b01, 100, 0, 0, 0, lat);
        check("x2_latency", lat, 166);
        check("x2_clear_writes", n_clr - s_clr, CLR);
        check("x2_go_cycles", n_go[1] - s_go, 100);
        check("x2_done", 32'(done), 32'd1);
        check("x2_busy", 32'(busy), 32'd0);
        check("x2_go_off", 32'(eng_go), 32'd0);

        // Copy with engine 0 pinned to addr 5 / data A5 while others are noise.
        ovr = 1'b1; s_ovr = n_ovr;
        run_job(2'b00, 10, 0, 0, 0, lat);
        ovr = 1'b0;
        check("copy_latency", lat, 76);
        check("copy_fwd_cycles", n_ovr - s_ovr, 10);

        // Reserved mode from DONE: error, no job, no writes.
        s_wr = n_wr;
        @(posedge clk); #1; start = 1'b1; mode = 2'b11;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("bad_no_write", n_wr - s_wr, 0);

        // Timeout with zoom x4: error exactly TMO cycles after run entry.
        s_go = n_go[2];
        run_job(2'b10, 0, 0, 0, 0, lat);
        check("tmo_latency", lat, 216);
        check("tmo_run_cycles", n_go[2] - s_go, TMO);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_done", 32'(done), 32'd0);
        check("tmo_go_off", 32'(eng_go), 32'd0);

        // Done in the very last run cycle beats the timeout.
        run_job(2'b01, TMO, 0, 0, 0, lat);
        check("prio_latency", lat, 216);
        check("prio_done", 32'(done), 32'd1);
        check("prio_error", 32'(error), 32'd0);

        // Spurious starts during clear (cycle 10) and run (cycle 70).
        s_clr = n_clr; s_go = n_go[0];
        run_job(2'b00, 20, 10, 70, 0, lat);
        check("ign_latency", lat, 86);
        check("ign_mode", 32'(active_mode), 32'd0);
        check("ign_clear_writes", n_clr - s_clr, CLR);
        check("ign_go_cycles", n_go[0] - s_go, 20);

        // Reset mid-run, then a full zoom x4 job.
        run_job(2'b01, 0, 0, 0, 80, lat);
        check("rst_idle_busy", 32'(busy), 32'd0);
        check("rst_idle_error", 32'(error), 32'd0);
        s_go = n_go[2];
        run_job(2'b10, 20, 0, 0, 0, lat);
        check("x4_latency", lat, 86);
        check("x4_go_cycles", n_go[2] - s_go, 20);
        check("x4_done", 32'(done), 32'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
